fetch_queue_unit: RTL and testbench
===================================

// Module: fetch_queue_unit
// PURPOSE
//   Parametrised instruction fetch stage: generates the PC and reads instruction memory at that PC.
//   Fetched {pc, instruction} pairs go into a small FIFO that decouples memory wait states from decode.
//   Supports branch/jump redirect with queue flush, halt, and a valid/ready handshake to decode.
//   Sits between instruction memory and the decode stage.
// PARAMETERS
//   ADDRESS_SIZE      `ADDRESS_SIZE      PC / memory address width in bits
//   INSTRUCTION_SIZE  `INSTRUCTION_SIZE  instruction word width in bits
//   QUEUE_DEPTH       4                  FIFO entries; power of two, >= 2
//   PC_STEP           1                  PC increment per sequential fetch
//   RESET_PC          0                  PC value after reset
// PORTS
//   clock           in   1                   clock; all state changes on its rising edge
//   reset           in   1                   reset, asynchronous, active-low
//   halt            in   1                   1 = freeze PC and suppress fetch; the queue still drains
//   redirect_valid  in   1                   1 = branch/jump taken this cycle
//   redirect_pc     in   ADDRESS_SIZE        target PC for the redirect
//   imem_addr       out  ADDRESS_SIZE        current PC, driven to instruction memory
//   imem_data       in   INSTRUCTION_SIZE    instruction at imem_addr
//   imem_ready      in   1                   imem_data is valid this cycle
//   inst_out        out  INSTRUCTION_SIZE    head instruction; `NOP_INST when the queue is empty
//   inst_pc_out     out  ADDRESS_SIZE        PC of the head instruction; 0 when the queue is empty
//   inst_valid      out  1                   queue not empty
//   inst_ready      in   1                   decode accepts the head entry this cycle
//   queue_count     out  $clog2(DEPTH)+1     number of occupied entries
//   stall_count     out  32                  only present with FETCH_STALL_COUNT_EN
// BEHAVIOUR
// - Reset (async, active-low): pc=RESET_PC, read/write pointers=0, count=0, inst_valid=0,
//   inst_out=`NOP_INST, inst_pc_out=0, stall_count=0. Assertion mid-operation clears all state at once.
// - pop = inst_valid & inst_ready.
// - fetch = imem_ready & ~halt & ~redirect_valid & (count<DEPTH | pop).
// - On fetch: write {pc, imem_data} at the write pointer; pc <= pc+PC_STEP, wrapping modulo 2^ADDRESS_SIZE.
// - Redirect has top priority: count<=0, pointers<=0, pc<=redirect_pc.
//   The pop and fetch in that cycle are discarded. inst_valid=0 on the next cycle.
// - Halt: pc and queue contents are frozen, except that pops continue. Redirect overrides halt.
// - Latency: an entry fetched in cycle N is visible at the head in cycle N+1. There is no bypass.
//   Head outputs are driven straight from registered state, with no combinational path from imem_data.
// - Push and pop in the same cycle: count unchanged. This is legal when full; the freed slot is reused.
// - Pop only: count-1. Push only: count+1. Pointers wrap modulo QUEUE_DEPTH.
// - Empty queue: inst_ready is ignored. Full queue without a pop: fetch suppressed, pc holds.
// - Order is strictly FIFO: entries leave in fetch order, and inst_pc_out always matches inst_out.
// CONFIGURATION
// - FETCH_STALL_COUNT_EN defined:
//   - stall_count port exists.
//   - It increments each cycle in which ~halt & ~redirect_valid & ~fetch
//     (memory wait or full queue).
//   - It saturates at 32'hFFFF_FFFF and resets to 0.
// - FETCH_STALL_COUNT_EN undefined: port and counter are absent; all other behaviour is identical.
// TESTING (QUEUE_DEPTH=4, RESET_PC=0, ADDRESS_SIZE=16, PC_STEP=1)
// - Release reset; imem_ready=1, inst_ready=1, imem_data=0x1000+addr
//   -> inst_valid=1 from cycle 1; inst_pc_out=0,1,2,3 on consecutive cycles with inst_out=0x1000.. .
// - inst_ready=0 for 6 cycles -> queue_count 1,2,3,4,4,4; imem_addr holds 4.
//   Then inst_ready=1 -> PCs 0,1,2,3 then 4 leave in order, each matching its instruction.
// - Queue at count=3; redirect_valid=1, redirect_pc=0x0040 with inst_ready=1
//   -> next cycle count=0, inst_valid=0, inst_out=`NOP_INST, imem_addr=0x0040; one cycle later head pc=0x0040.
// - Full queue, inst_ready=1, imem_ready=1 -> count stays 4 and pc increments every cycle.
//   Then imem_ready=0 for 3 cycles -> queue drains to 1;
//   with FETCH_STALL_COUNT_EN, stall_count increases by 3.
// - halt=1 with count=4, inst_ready=1 -> 4 pops, then inst_valid=0 and inst_out=`NOP_INST; pc frozen throughout.
//   Then redirect during halt -> pc=redirect_pc.
// - RESET_PC=0xFFFE -> fetched PCs 0xFFFE, 0xFFFF, 0x0000.
//   Assert reset mid-stream -> count, pc and outputs take reset values immediately, without a clock edge.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: PC generator and instruction FIFO feeding decode.
// Define FETCH_STALL_COUNT_EN to add the stall_count port and counter.
// ADDRESS_SIZE, INSTRUCTION_SIZE and NOP_INST fall back to local defaults if the codebase has not set them.
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 16
`endif
`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 32
`endif
`ifndef NOP_INST
`define NOP_INST 32'h0000_0013
`endif

module fetch_queue_unit #(
    parameter int ADDRESS_SIZE = `ADDRESS_SIZE,
    parameter int INSTRUCTION_SIZE = `INSTRUCTION_SIZE,
    parameter int QUEUE_DEPTH = 4,
    parameter int PC_STEP = 1,
    parameter logic [ADDRESS_SIZE-1:0] RESET_PC = '0
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              halt,
    input  logic                              redirect_valid,
    input  logic [ADDRESS_SIZE-1:0]           redirect_pc,
    output logic [ADDRESS_SIZE-1:0]           imem_addr,
    input  logic [INSTRUCTION_SIZE-1:0]       imem_data,
    input  logic                              imem_ready,
    output logic [INSTRUCTION_SIZE-1:0]       inst_out,
    output logic [ADDRESS_SIZE-1:0]           inst_pc_out,
    output logic                              inst_valid,
    input  logic                              inst_ready,
`ifdef FETCH_STALL_COUNT_EN
    output logic [31:0]                       stall_count,
`endif
    output logic [$clog2(QUEUE_DEPTH):0]      queue_count
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);
    localparam logic [INSTRUCTION_SIZE-1:0] NOP = INSTRUCTION_SIZE'(`NOP_INST);
    logic [ADDRESS_SIZE-1:0] pc;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [ADDRESS_SIZE-1:0] pc_q [QUEUE_DEPTH];
    logic [INSTRUCTION_SIZE-1:0] inst_q [QUEUE_DEPTH];
    logic pop, fetch;
    // Handshake and fetch qualification; head is read straight from the registered queue.
    always_comb begin
        inst_valid = count != '0;
        pop = inst_valid & inst_ready;
        fetch = imem_ready & ~halt & ~redirect_valid & (count < FULL | pop);
        imem_addr = pc;
        queue_count = count;
        inst_out = inst_valid ? inst_q[rd_ptr] : NOP;
        inst_pc_out = inst_valid ? pc_q[rd_ptr] : '0;
    end
    // PC, pointers and occupancy; redirect flushes and discards same-cycle push/pop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (fetch) pc <= pc + ADDRESS_SIZE'(PC_STEP);
            if (fetch) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(fetch) - CW'(pop);
        end
    end
    // Queue storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clock) begin
        if (reset && fetch) begin
            pc_q[wr_ptr] <= pc;
            inst_q[wr_ptr] <= imem_data;
        end
    end
`ifdef FETCH_STALL_COUNT_EN
    // Saturating count of cycles lost to memory wait or a full queue.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) stall_count <= '0;
        else if (~halt & ~redirect_valid & ~fetch & (stall_count != '1)) stall_count <= stall_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed checks of fetch, FIFO order, redirect, halt, PC wrap and async reset.
`ifndef NOP_INST
`define NOP_INST 32'h0000_0013
`endif

module tb_fetch_queue_unit;
    localparam logic [31:0] NOP = `NOP_INST;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic halt = 1'b0;
    logic redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic imem_ready = 1'b1;
    logic inst_ready = 1'b1;
    logic [15:0] imem_addr, inst_pc_out, imem_addr_w, inst_pc_out_w;
    logic [31:0] imem_data, inst_out, imem_data_w, inst_out_w;
    logic inst_valid, inst_valid_w;
    logic [2:0] queue_count, queue_count_w;
`ifdef FETCH_STALL_COUNT_EN
    logic [31:0] stall_count, stall_count_w;
`endif
    int tests = 0;
    int fails = 0;

    assign imem_data = 32'h1000 + {16'h0, imem_addr};
    assign imem_data_w = 32'h1000 + {16'h0, imem_addr_w};

    always #5 clock = ~clock;

    fetch_queue_unit #(.ADDRESS_SIZE(16), .INSTRUCTION_SIZE(32), .QUEUE_DEPTH(4), .PC_STEP(1), .RESET_PC(16'h0000)) dut (
        .clock(clock), .reset(reset), .halt(halt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_data(imem_data), .imem_ready(imem_ready),
        .inst_out(inst_out), .inst_pc_out(inst_pc_out), .inst_valid(inst_valid), .inst_ready(inst_ready),
`ifdef FETCH_STALL_COUNT_EN
        .stall_count(stall_count),
`endif
        .queue_count(queue_count));

    fetch_queue_unit #(.ADDRESS_SIZE(16), .INSTRUCTION_SIZE(32), .QUEUE_DEPTH(4), .PC_STEP(1), .RESET_PC(16'hFFFE)) u_wrap (
        .clock(clock), .reset(reset), .halt(halt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr_w), .imem_data(imem_data_w), .imem_ready(imem_ready),
        .inst_out(inst_out_w), .inst_pc_out(inst_pc_out_w), .inst_valid(inst_valid_w), .inst_ready(inst_ready),
`ifdef FETCH_STALL_COUNT_EN
        .stall_count(stall_count_w),
`endif
        .queue_count(queue_count_w));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic rdy_in);
        reset = 1'b0;
        halt = 1'b0;
        redirect_valid = 1'b0;
        imem_ready = 1'b1;
        inst_ready = rdy_in;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tests++;
        if (queue_count !== 3'd0 || inst_valid !== 1'b0 || inst_out !== NOP || inst_pc_out !== 16'h0 || imem_addr !== 16'h0) begin
            fails++;
            $display("FAIL reset_state: count=%0d valid=%b inst=%h pc=%h addr=%h, required 0 0 %h 0 0", queue_count, inst_valid, inst_out, inst_pc_out, imem_addr, NOP);
        end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (inst_valid !== 1'b1 || inst_pc_out !== 16'(k) || inst_out !== 32'h1000 + k || queue_count !== 3'd1) begin
                fails++;
                $display("FAIL stream_%0d: valid=%b pc=%h inst=%h count=%0d, required 1 %h %h 1", k, inst_valid, inst_pc_out, inst_out, queue_count, k, 32'h1000 + k);
            end
        end
    endtask

    task automatic test_fill_drain();
        logic [2:0] exp_cnt [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
        do_reset(1'b0);
        for (int k = 0; k < 6; k++) begin
            tick();
            tests++;
            if (queue_count !== exp_cnt[k]) begin
                fails++;
                $display("FAIL fill_count_%0d: got %0d, required %0d", k, queue_count, exp_cnt[k]);
            end
        end
        tests++;
        if (imem_addr !== 16'd4) begin
            fails++;
            $display("FAIL full_pc_hold: got %h, required 0004", imem_addr);
        end
        inst_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (inst_pc_out !== 16'(k) || inst_out !== 32'h1000 + k) begin
                fails++;
                $display("FAIL drain_order_%0d: pc=%h inst=%h, required %h %h", k, inst_pc_out, inst_out, k, 32'h1000 + k);
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        tick();
        tick();
        tick();
        tests++;
        if (queue_count !== 3'd3) begin
            fails++;
            $display("FAIL redirect_setup: count=%0d, required 3", queue_count);
        end
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        tests++;
        if (queue_count !== 3'd0 || inst_valid !== 1'b0 || inst_out !== NOP || inst_pc_out !== 16'h0 || imem_addr !== 16'h0040) begin
            fails++;
            $display("FAIL redirect_flush: count=%0d valid=%b inst=%h pc=%h addr=%h, required 0 0 %h 0 0040", queue_count, inst_valid, inst_out, inst_pc_out, imem_addr, NOP);
        end
        tick();
        tests++;
        if (inst_valid !== 1'b1 || inst_pc_out !== 16'h0040 || inst_out !== 32'h1040) begin
            fails++;
            $display("FAIL redirect_target: valid=%b pc=%h inst=%h, required 1 0040 00001040", inst_valid, inst_pc_out, inst_out);
        end
    endtask

    task automatic test_full_pushpop();
`ifdef FETCH_STALL_COUNT_EN
        logic [31:0] s0;
`endif
        do_reset(1'b0);
        for (int k = 0; k < 4; k++) tick();
        inst_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (queue_count !== 3'd4 || imem_addr !== 16'(5 + k) || inst_pc_out !== 16'(k + 1)) begin
                fails++;
                $display("FAIL full_pushpop_%0d: count=%0d addr=%h head=%h, required 4 %h %h", k, queue_count, imem_addr, inst_pc_out, 5 + k, k + 1);
            end
        end
`ifdef FETCH_STALL_COUNT_EN
        s0 = stall_count;
`endif
        imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        tests++;
        if (queue_count !== 3'd1 || imem_addr !== 16'd7 || inst_pc_out !== 16'd6) begin
            fails++;
            $display("FAIL mem_wait_drain: count=%0d addr=%h head=%h, required 1 0007 0006", queue_count, imem_addr, inst_pc_out);
        end
`ifdef FETCH_STALL_COUNT_EN
        tests++;
        if (stall_count !== s0 + 32'd3) begin
            fails++;
            $display("FAIL stall_count: got %0d, required %0d", stall_count, s0 + 32'd3);
        end
`endif
        imem_ready = 1'b1;
    endtask

    task automatic test_halt();
        do_reset(1'b0);
        for (int k = 0; k < 4; k++) tick();
        halt = 1'b1;
        inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (queue_count !== 3'(3 - k) || imem_addr !== 16'd4 || (k < 3 && inst_pc_out !== 16'(k + 1))) begin
                fails++;
                $display("FAIL halt_drain_%0d: count=%0d addr=%h head=%h, required %0d 0004 %h", k, queue_count, imem_addr, inst_pc_out, 3 - k, k + 1);
            end
        end
        tests++;
        if (inst_valid !== 1'b0 || inst_out !== NOP || inst_pc_out !== 16'h0) begin
            fails++;
            $display("FAIL halt_empty: valid=%b inst=%h pc=%h, required 0 %h 0", inst_valid, inst_out, inst_pc_out, NOP);
        end
        redirect_valid = 1'b1;
        redirect_pc = 16'h0123;
        tick();
        redirect_valid = 1'b0;
        tick();
        tests++;
        if (imem_addr !== 16'h0123 || queue_count !== 3'd0) begin
            fails++;
            $display("FAIL halt_redirect: addr=%h count=%0d, required 0123 0", imem_addr, queue_count);
        end
        halt = 1'b0;
    endtask

    task automatic test_wrap_async_reset();
        logic [15:0] exp_pc [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
        do_reset(1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (inst_valid_w !== 1'b1 || inst_pc_out_w !== exp_pc[k] || inst_out_w !== 32'h1000 + {16'h0, exp_pc[k]}) begin
                fails++;
                $display("FAIL pc_wrap_%0d: valid=%b pc=%h inst=%h, required 1 %h %h", k, inst_valid_w, inst_pc_out_w, inst_out_w, exp_pc[k], 32'h1000 + {16'h0, exp_pc[k]});
            end
        end
        inst_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #2;
        tests++;
        if (queue_count_w !== 3'd0 || imem_addr_w !== 16'hFFFE || inst_valid_w !== 1'b0 || inst_out_w !== NOP || inst_pc_out_w !== 16'h0) begin
            fails++;
            $display("FAIL async_reset_wrap: count=%0d addr=%h valid=%b inst=%h pc=%h, required 0 fffe 0 %h 0", queue_count_w, imem_addr_w, inst_valid_w, inst_out_w, inst_pc_out_w, NOP);
        end
        tests++;
        if (queue_count !== 3'd0 || imem_addr !== 16'h0 || inst_valid !== 1'b0 || inst_out !== NOP) begin
            fails++;
            $display("FAIL async_reset_main: count=%0d addr=%h valid=%b inst=%h, required 0 0 0 %h", queue_count, imem_addr, inst_valid, inst_out, NOP);
        end
`ifdef FETCH_STALL_COUNT_EN
        tests++;
        if (stall_count !== 32'd0) begin
            fails++;
            $display("FAIL async_reset_stall: got %0d, required 0", stall_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill_drain();
        test_redirect();
        test_full_pushpop();
        test_halt();
        test_wrap_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
